window_stats: RTL and testbench

- Parametrised successor to the team's mean/variance engine.
- Computes the integer mean and the population or sample variance of unsigned samples over an index window [si, ei).
- Reads the samples itself from an external synchronous memory through an index/value port with configurable read latency.
- Sits between the sample buffer and the predictor's feature stage; a start/done handshake frames each computation.

---
 rtl/stats_pkg.sv | 24 ++
 rtl/seq_divider.sv | 74 +++++++
 rtl/window_stats.sv | 223 ++++++++++++++++++++++
 tb/tb_window_stats.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/stats_pkg.sv
// Shared types and helpers for the windowed mean/variance engine.
package stats_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StFetch,
    StDrain,
    StMul,
    StDivMean,
    StDivVar,
    StFinish
  } state_e;

  localparam logic MODE_POP    = 1'b0;
  localparam logic MODE_SAMPLE = 1'b1;

  // Width of a sum of up to 2^cw-1 terms, each a pow-th power of a dw-bit sample.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned pow,
                                            input int unsigned cw);
    return pow * dw + cw;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per division.
module seq_divider #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(W) + 1;

  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [W:0]   rem_sh;
  logic [W-1:0] rem_sub;
  logic         q_bit;
  logic [W-1:0] quo_next;

  always_comb begin
    rem_sh   = {rem_q, quo_q[W-1]};
    q_bit    = rem_sh >= {1'b0, dvs_q};
    // Only used when rem_sh >= divisor, so the true difference fits in W bits.
    rem_sub  = rem_sh[W-1:0] - dvs_q;
    quo_next = {quo_q[W-2:0], q_bit};
    done_o   = busy_q && (cnt_q == CntW'(W - 1));

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    // A start in the final iteration cycle wins; the caller takes quotient_o that cycle.
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = quo_next;
      rem_d = q_bit ? rem_sub : rem_sh[W-1:0];
      cnt_d = cnt_q + CntW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  assign quotient_o = quo_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/window_stats.sv
// Integer mean and population/sample variance of samples read from memory over [si, ei).
module window_stats
  import stats_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned CW      = 16,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned DIV_W   = 2 * DW + 2 * CW
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            start,
  input  logic            mode,
  input  logic [AW-1:0]   si,
  input  logic [AW-1:0]   ei,
  output logic [AW-1:0]   index,
  input  logic [DW-1:0]   value,
  output logic [DW-1:0]   mean,
  output logic [2*DW-1:0] variance,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned SW = acc_width(DW, 1, CW);
  localparam int unsigned QW = acc_width(DW, 2, CW);
  localparam int unsigned XW = AW + CW;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [AW-1:0]     si_q, si_d, ei_q, ei_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     index_q, index_d;
  logic [DW-1:0]     value_q;
  logic [MEM_LAT:0]  vld_q, vld_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [QW-1:0]     sumsq_q, sumsq_d;
  logic [DIV_W-1:0]  num_q, num_d, den_q, den_d;
  logic [DW-1:0]     q1_q, q1_d;
  logic [DW-1:0]     mean_q, mean_d;
  logic [2*DW-1:0]   var_q, var_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              div_start, div_done;
  logic [DIV_W-1:0]  div_dvd, div_dvs, div_quo;

  logic [AW-1:0]     diff;
  logic              too_big;
  logic [CW-1:0]     nm1;
  logic [DIV_W-1:0]  den_full;

  assign diff    = ei_q - si_q;
  assign too_big = XW'(diff) > XW'({CW{1'b1}});
  assign nm1     = n_q - CW'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    si_d      = si_q;
    ei_d      = ei_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    index_d   = index_q;
    sum_d     = sum_q;
    sumsq_d   = sumsq_q;
    num_d     = num_q;
    den_d     = den_q;
    q1_d      = q1_q;
    mean_d    = mean_q;
    var_d     = var_q;
    err_d     = err_q;
    div_start = 1'b0;
    div_dvd   = num_q;
    div_dvs   = den_q;
    den_full  = '0;

    // Tag each issued read; the tag reaches the top MEM_LAT+1 cycles later, aligned with
    // value_q (memory latency plus the input register).
    vld_d[0] = (state_q == StFetch);
    for (int i = 1; i <= int'(MEM_LAT); i++) vld_d[i] = vld_q[i-1];

    if (vld_q[MEM_LAT]) begin
      sum_d   = sum_q + SW'(value_q);
      sumsq_d = sumsq_q + QW'(value_q) * QW'(value_q);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          si_d    = si;
          ei_d    = ei;
          mode_d  = mode;
          err_d   = 1'b0;
          sum_d   = '0;
          sumsq_d = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((ei_q <= si_q) || too_big) begin
          err_d   = 1'b1;
          mean_d  = '0;
          var_d   = '0;
          state_d = StFinish;
        end else begin
          n_d     = CW'(diff);
          index_d = si_q;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (cnt_q == nm1) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          index_d = index_q + AW'(1);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CW'(MEM_LAT)) state_d = StMul;
        else cnt_d = cnt_q + CW'(1);
      end
      StMul: begin
        num_d = DIV_W'(n_q) * DIV_W'(sumsq_q) - DIV_W'(sum_q) * DIV_W'(sum_q);
        if (mode_q == MODE_SAMPLE) den_full = DIV_W'(n_q) * DIV_W'(nm1);
        else den_full = DIV_W'(n_q) * DIV_W'(n_q);
        // Sample variance of a single sample: numerator is 0, so any non-zero divisor gives 0.
        den_d     = (den_full == '0) ? DIV_W'(1) : den_full;
        div_start = 1'b1;
        div_dvd   = DIV_W'(sum_q);
        div_dvs   = DIV_W'(n_q);
        state_d   = StDivMean;
      end
      StDivMean: begin
        if (div_done) begin
          q1_d      = div_quo[DW-1:0];
          div_start = 1'b1;
          state_d   = StDivVar;
        end
      end
      StDivVar: begin
        if (div_done) begin
          mean_d  = q1_q;
          var_d   = div_quo[2*DW-1:0];
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    done_d = (state_d == StFinish);
    busy_d = (state_d != StIdle) && (state_d != StFinish);
  end

  seq_divider #(
    .W (DIV_W)
  ) u_div (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .start_i    (div_start),
    .dividend_i (div_dvd),
    .divisor_i  (div_dvs),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      si_q    <= '0;
      ei_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      index_q <= '0;
      value_q <= '0;
      vld_q   <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
      num_q   <= '0;
      den_q   <= '0;
      q1_q    <= '0;
      mean_q  <= '0;
      var_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      si_q    <= si_d;
      ei_q    <= ei_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      value_q <= value;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      num_q   <= num_d;
      den_q   <= den_d;
      q1_q    <= q1_d;
      mean_q  <= mean_d;
      var_q   <= var_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign index    = index_q;
  assign mean     = mean_q;
  assign variance = var_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_window_stats.sv
// Directed scoreboard bench for window_stats: default build (MEM_LAT=1) and an 8-bit MEM_LAT=3 build.
module tb_window_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mode;
  logic [31:0] si, ei;

  logic        start_a, busy_a, done_a, err_a;
  logic [31:0] index_a, value_a, mean_a;
  logic [63:0] var_a;

  logic        start_b, busy_b, done_b, err_b;
  logic [31:0] index_b;
  logic [7:0]  value_b, mean_b, pb1, pb2;
  logic [15:0] var_b;

  logic [31:0] mem_a [10];
  logic [7:0]  mem_b [4];

  window_stats u_dut_a (
    .Clk(clk), .Rst(rst_n), .start(start_a), .mode(mode), .si(si), .ei(ei),
    .index(index_a), .value(value_a), .mean(mean_a), .variance(var_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  window_stats #(.DW(8), .MEM_LAT(3)) u_dut_b (
    .Clk(clk), .Rst(rst_n), .start(start_b), .mode(mode), .si(si), .ei(ei),
    .index(index_b), .value(value_b), .mean(mean_b), .variance(var_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Synchronous memories: one-cycle latency for A, three-stage pipe for B.
  always @(posedge clk) value_a <= (index_a < 32'd10) ? mem_a[index_a[3:0]] : 32'd0;
  always @(posedge clk) begin
    pb1     <= (index_b < 32'd4) ? mem_b[index_b[1:0]] : 8'd0;
    pb2     <= pb1;
    value_b <= pb2;
  end

  typedef struct {
    logic [63:0]  m;
    logic [127:0] v;
    logic         e;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  // Launch one job, optionally re-pulse start mid-run on A, and score the result at done.
  task automatic run_job(input bit sel, input int s, input int e, input bit md,
                         input logic [63:0] em, input logic [127:0] ev, input bit ee,
                         input int el, input bit poke);
    exp_t x;
    int   lat;
    logic dn;
    sb.push_back('{m: em, v: ev, e: ee, lat: el});
    si = s; ei = e; mode = md;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    lat = 1;
    check("busy_after_start", sel ? busy_b : busy_a, 1);
    dn = sel_done(sel);
    while (!dn && lat < 1000) begin
      if (poke && lat == 5) begin
        si = 2; ei = 5; mode = 1'b1; start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0;
      lat++;
      dn = sel_done(sel);
    end
    x = sb.pop_front();
    check("done_seen", dn, 1);
    check("latency", lat, x.lat);
    check("mean", sel ? mean_b : mean_a, x.m);
    check("variance", sel ? var_b : var_a, x.v);
    check("err", sel ? err_b : err_a, x.e);
    check("busy_at_done", sel ? busy_b : busy_a, 0);
    @(posedge clk); #1;
    check("done_one_cycle", sel_done(sel), 0);
  endtask

  initial begin
    int dcount;
    mem_a[0] = 3;  mem_a[1] = 17; mem_a[2] = 11; mem_a[3] = 5;  mem_a[4] = 9;
    mem_a[5] = 10; mem_a[6] = 11; mem_a[7] = 15; mem_a[8] = 8;  mem_a[9] = 12;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'd255;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; si = 0; ei = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_index", index_a, 0);
    check("rst_mean", mean_a, 0);
    check("rst_var", var_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_b_busy", busy_b, 0);

    // Valid-window latency on A: N + 1 + 2*96 + 4; error path: 2.
    run_job(0, 0, 10, 0, 10, 15, 0, 207, 0);
    run_job(0, 0, 10, 1, 10, 17, 0, 207, 0);
    run_job(0, 2, 5, 0, 8, 6, 0, 200, 0);
    run_job(0, 2, 5, 1, 8, 9, 0, 200, 0);
    run_job(0, 5, 5, 0, 0, 0, 1, 2, 0);
    run_job(0, 7, 3, 1, 0, 0, 1, 2, 0);
    run_job(0, 3, 4, 1, 5, 0, 0, 198, 0);

    // Reset during FETCH aborts the job and clears the outputs.
    si = 0; ei = 10; mode = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_mean", mean_a, 0);
    check("abort_index", index_a, 0);
    dcount = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (done_a) dcount++;
    end
    check("abort_no_done", dcount, 0);

    run_job(0, 0, 10, 0, 10, 15, 0, 207, 0);
    run_job(0, 0, 10, 0, 10, 15, 0, 207, 1);

    // B: DW=8, MEM_LAT=3, DIV_W=48 -> latency 4 + 3 + 96 + 4.
    run_job(1, 0, 4, 0, 255, 0, 0, 107, 0);
    mem_b[0] = 8'd0; mem_b[2] = 8'd0;
    run_job(1, 0, 4, 0, 127, 16256, 0, 107, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
